// File: rtl/ccu_pkg.sv
// ccu_pkg: shared definitions for the graphics-processor control unit.
//   - opcode values sampled on cmd
//   - Kbus bit positions and field ranges
//   - alu_op / operand-select / destination encodings
//   - kbus_t field struct and pack_kbus() to form the 24-bit control word
package ccu_pkg;

  // Opcodes (decimal values of cmd)
  localparam logic [7:0] OP_NOP   = 8'd0;
  localparam logic [7:0] OP_MOV   = 8'd2;
  localparam logic [7:0] OP_ADD   = 8'd4;
  localparam logic [7:0] OP_SUB   = 8'd6;
  localparam logic [7:0] OP_AND   = 8'd8;
  localparam logic [7:0] OP_OR    = 8'd10;
  localparam logic [7:0] OP_XOR   = 8'd12;
  localparam logic [7:0] OP_SHL   = 8'd14;
  localparam logic [7:0] OP_SHR   = 8'd16;
  localparam logic [7:0] OP_LOAD  = 8'd18;
  localparam logic [7:0] OP_STORE = 8'd20;
  localparam logic [7:0] OP_PLOT  = 8'd22;
  localparam logic [7:0] OP_JMP   = 8'd24;
  localparam logic [7:0] OP_HALT  = 8'd76;

  // Kbus bit positions
  localparam int KB_VALID   = 23;
  localparam int KB_ILLEGAL = 22;
  localparam int KB_PHASE   = 21;
  localparam int KB_ALU_HI  = 20;
  localparam int KB_ALU_LO  = 17;
  localparam int KB_SRCA_HI = 16;
  localparam int KB_SRCA_LO = 14;
  localparam int KB_SRCB_HI = 13;
  localparam int KB_SRCB_LO = 11;
  localparam int KB_DST_HI  = 10;
  localparam int KB_DST_LO  = 8;
  localparam int KB_REG_WE  = 7;
  localparam int KB_MEM_RD  = 6;
  localparam int KB_MEM_WR  = 5;
  localparam int KB_PIX_WE  = 4;
  localparam int KB_PC_INC  = 3;
  localparam int KB_PC_LOAD = 2;
  localparam int KB_FLAG_WE = 1;
  localparam int KB_HALT    = 0;

  // ALU operation encodings
  localparam logic [3:0] ALU_PASS = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SHL  = 4'd6;
  localparam logic [3:0] ALU_SHR  = 4'd7;

  // Operand source selects
  localparam logic [2:0] SEL_NONE = 3'd0;
  localparam logic [2:0] SEL_RD   = 3'd1;
  localparam logic [2:0] SEL_RS   = 3'd2;
  localparam logic [2:0] SEL_MEM  = 3'd3;
  localparam logic [2:0] SEL_IMM  = 3'd4;

  // Destination selects
  localparam logic [2:0] DST_NONE = 3'd0;
  localparam logic [2:0] DST_RD   = 3'd1;

  // Fixed control words
  localparam logic [23:0] KBUS_RESET   = 24'h000000;
  localparam logic [23:0] KBUS_ILLEGAL = 24'h400000;
  localparam logic [23:0] KBUS_HALT    = 24'h800001;

  typedef struct packed {
    logic       valid;
    logic       illegal;
    logic       phase;
    logic [3:0] alu_op;
    logic [2:0] src_a;
    logic [2:0] src_b;
    logic [2:0] dst;
    logic       reg_we;
    logic       mem_rd;
    logic       mem_wr;
    logic       pix_we;
    logic       pc_inc;
    logic       pc_load;
    logic       flag_we;
    logic       halt;
  } kbus_t;

  // Place each field at its named Kbus position.
  function automatic logic [23:0] pack_kbus(input kbus_t f);
    logic [23:0] w;
    w = 24'h000000;
    w[KB_VALID]              = f.valid;
    w[KB_ILLEGAL]            = f.illegal;
    w[KB_PHASE]              = f.phase;
    w[KB_ALU_HI:KB_ALU_LO]   = f.alu_op;
    w[KB_SRCA_HI:KB_SRCA_LO] = f.src_a;
    w[KB_SRCB_HI:KB_SRCB_LO] = f.src_b;
    w[KB_DST_HI:KB_DST_LO]   = f.dst;
    w[KB_REG_WE]             = f.reg_we;
    w[KB_MEM_RD]             = f.mem_rd;
    w[KB_MEM_WR]             = f.mem_wr;
    w[KB_PIX_WE]             = f.pix_we;
    w[KB_PC_INC]             = f.pc_inc;
    w[KB_PC_LOAD]            = f.pc_load;
    w[KB_FLAG_WE]            = f.flag_we;
    w[KB_HALT]               = f.halt;
    return w;
  endfunction

endpackage

// File: rtl/ccu_decode.sv
// ccu_decode: combinational opcode decoder.
//   cmd       in  8   opcode to decode (held opcode during a second phase)
//   phase     in  1   1 = produce the second-phase word of a two-phase command
//   kbus_next out 24  control word to be registered onto Kbus
//   two_phase out 1   command needs a second phase on the next edge
module ccu_decode
  import ccu_pkg::*;
(
  input  logic [7:0]  cmd,
  input  logic        phase,
  output logic [23:0] kbus_next,
  output logic        two_phase
);

  kbus_t f_s;
  logic  illegal_s;

  // Opcode to control-field decode; anything unlisted (including X) is illegal.
  always_comb begin
    f_s       = '0;
    illegal_s = 1'b0;
    two_phase = 1'b0;
    case (cmd)
      OP_NOP: begin
        f_s.valid  = 1'b1;
        f_s.pc_inc = 1'b1;
      end
      OP_MOV: begin
        f_s.valid  = 1'b1;
        f_s.alu_op = ALU_PASS;
        f_s.src_a  = SEL_RD;
        f_s.dst    = DST_RD;
        f_s.reg_we = 1'b1;
        f_s.pc_inc = 1'b1;
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        // Opcodes 4..12 step by 2, so cmd/2 - 1 gives alu_op 1..5.
        f_s.valid   = 1'b1;
        f_s.alu_op  = cmd[4:1] - 4'd1;
        f_s.src_a   = SEL_RD;
        f_s.src_b   = SEL_RS;
        f_s.dst     = DST_RD;
        f_s.reg_we  = 1'b1;
        f_s.flag_we = 1'b1;
        f_s.pc_inc  = 1'b1;
      end
      OP_SHL, OP_SHR: begin
        f_s.valid   = 1'b1;
        f_s.alu_op  = cmd[4:1] - 4'd1;
        f_s.src_a   = SEL_RD;
        f_s.dst     = DST_RD;
        f_s.reg_we  = 1'b1;
        f_s.flag_we = 1'b1;
        f_s.pc_inc  = 1'b1;
      end
      OP_LOAD: begin
        f_s.valid = 1'b1;
        if (phase) begin
          f_s.phase  = 1'b1;
          f_s.src_a  = SEL_MEM;
          f_s.dst    = DST_RD;
          f_s.reg_we = 1'b1;
          f_s.pc_inc = 1'b1;
        end else begin
          f_s.src_a  = SEL_RS;
          f_s.mem_rd = 1'b1;
          two_phase  = 1'b1;
        end
      end
      OP_STORE: begin
        f_s.valid = 1'b1;
        if (phase) begin
          f_s.phase  = 1'b1;
          f_s.pc_inc = 1'b1;
        end else begin
          f_s.src_a  = SEL_RS;
          f_s.src_b  = SEL_RD;
          f_s.mem_wr = 1'b1;
          two_phase  = 1'b1;
        end
      end
      OP_PLOT: begin
        f_s.valid  = 1'b1;
        f_s.src_a  = SEL_RD;
        f_s.src_b  = SEL_RS;
        f_s.pix_we = 1'b1;
        f_s.pc_inc = 1'b1;
      end
      OP_JMP: begin
        f_s.valid   = 1'b1;
        f_s.src_a   = SEL_IMM;
        f_s.pc_load = 1'b1;
      end
      OP_HALT: begin
        f_s.valid = 1'b1;
        f_s.halt  = 1'b1;
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase

    if (illegal_s) begin
      kbus_next = KBUS_ILLEGAL;
    end else begin
      kbus_next = pack_kbus(f_s);
    end
  end

endmodule

// File: rtl/ccu_ctrl.sv
// ccu_ctrl: central control unit of the graphics processor.
//   clk   in  1   system clock, rising edge
//   rst_n in  1   asynchronous active-low reset
//   cmd   in  8   opcode, sampled each rising edge
//   Kbus  out 24  registered control word to the datapath
// Two-phase commands (LOAD/STORE) hold their opcode and issue the second
// phase on the next edge regardless of cmd. HALT is sticky until reset.
module ccu_ctrl
  import ccu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  cmd,
  output logic [23:0] Kbus
);

  logic        phase_r;
  logic        halted_r;
  logic [7:0]  op_r;
  logic [23:0] kbus_r;

  logic [7:0]  dec_cmd_s;
  logic [23:0] dec_word_s;
  logic        dec_two_s;

  // During the second phase the held opcode is decoded instead of cmd.
  always_comb begin
    if (phase_r) begin
      dec_cmd_s = op_r;
    end else begin
      dec_cmd_s = cmd;
    end
  end

  ccu_decode u_decode (
    .cmd       (dec_cmd_s),
    .phase     (phase_r),
    .kbus_next (dec_word_s),
    .two_phase (dec_two_s)
  );

  // Control state and the registered control word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r  <= 1'b0;
      halted_r <= 1'b0;
      op_r     <= 8'd0;
      kbus_r   <= KBUS_RESET;
    end else if (halted_r) begin
      kbus_r   <= KBUS_HALT;
    end else if (phase_r) begin
      kbus_r   <= dec_word_s;
      phase_r  <= 1'b0;
    end else begin
      kbus_r   <= dec_word_s;
      phase_r  <= dec_two_s;
      op_r     <= cmd;
      halted_r <= (cmd == OP_HALT);
    end
  end

  assign Kbus = kbus_r;

endmodule

// File: tb/tb_ccu_ctrl.sv
// tb_ccu_ctrl: scoreboard bench for ccu_ctrl. The driver applies cmd on the
// falling edge and queues the word expected after the next rising edge; the
// monitor pops and compares just after each rising edge, or right after an
// explicit asynchronous-reset request.
module tb_ccu_ctrl;

  logic        clk;
  logic        rst_n;
  logic [7:0]  cmd;
  logic [23:0] Kbus;

  typedef struct {
    logic [23:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_vec;
  int   n_fail;
  event chk_ev;

  ccu_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cmd   (cmd),
    .Kbus  (Kbus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Monitor / scoreboard
  initial begin
    exp_t it;
    n_vec  = 0;
    n_fail = 0;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      if (q.size() > 0) begin
        it = q.pop_front();
        n_vec++;
        if (Kbus !== it.exp) begin
          n_fail++;
          $display("FAIL %s: Kbus=%h required %h", it.name, Kbus, it.exp);
        end
      end
    end
  end

  task automatic step(input logic [7:0] c, input logic [23:0] e, input string nm);
    @(negedge clk);
    cmd = c;
    q.push_back('{e, nm});
  endtask

  // Mid-cycle async reset, one held-reset edge, then release with a first vector.
  task automatic reset_pulse(input logic [7:0] c, input logic [23:0] e, input string nm);
    @(negedge clk);
    cmd = 8'd0;
    #2;
    rst_n = 1'b0;
    q.push_back('{24'h000000, "async_rst"});
    -> chk_ev;
    @(negedge clk);
    q.push_back('{24'h000000, "rst_hold"});
    @(negedge clk);
    rst_n = 1'b1;
    cmd = c;
    q.push_back('{e, nm});
  endtask

  initial begin
    rst_n = 1'b0;
    cmd   = 8'd0;

    // Reset held across clock edges
    @(negedge clk);
    q.push_back('{24'h000000, "rst_idle0"});
    @(negedge clk);
    q.push_back('{24'h000000, "rst_idle1"});
    @(negedge clk);
    rst_n = 1'b1;
    cmd   = 8'd0;
    q.push_back('{24'h800008, "nop_first"});

    // Single-cycle decode
    step(8'd4, 24'h82518A, "add");
    step(8'd2, 24'h804188, "mov");

    // LOAD: second phase ignores cmd
    step(8'd18, 24'h808040, "load_p0");
    step(8'd4,  24'hA0C188, "load_p1");
    step(8'd4,  24'h82518A, "add_after_load");

    // Illegal commands
    step(8'd3,   24'h400000, "illegal_3");
    step(8'd200, 24'h400000, "illegal_200");
    step(8'd0,   24'h800008, "nop_after_illegal");

    // HALT is sticky
    step(8'd76, 24'h800001, "halt");
    step(8'd0,  24'h800001, "halt_hold_nop");
    step(8'd4,  24'h800001, "halt_hold_add");
    step(8'd18, 24'h800001, "halt_hold_load");
    reset_pulse(8'd0, 24'h800008, "nop_after_halt_rst");

    // Sweep of legal opcodes
    step(8'd2,  24'h804188, "sw_mov");
    step(8'd4,  24'h82518A, "sw_add");
    step(8'd6,  24'h84518A, "sw_sub");
    step(8'd8,  24'h86518A, "sw_and");
    step(8'd10, 24'h88518A, "sw_or");
    step(8'd12, 24'h8A518A, "sw_xor");
    step(8'd14, 24'h8C418A, "sw_shl");
    step(8'd16, 24'h8E418A, "sw_shr");
    step(8'd18, 24'h808040, "sw_load_p0");
    step(8'd0,  24'hA0C188, "sw_load_p1");
    step(8'd20, 24'h808820, "sw_store_p0");
    step(8'd76, 24'hA00008, "sw_store_p1_ignores_halt");
    step(8'd22, 24'h805018, "sw_plot");
    step(8'd24, 24'h810004, "sw_jmp");
    step(8'd0,  24'h800008, "sw_nop_after_jmp");

    // Drain: the monitor pops one entry per edge
    repeat (4) @(posedge clk);
    #2;
    if (Kbus !== 24'h800008) begin
      n_fail++;
      $display("FAIL final_nop_hold: Kbus=%h required %h", Kbus, 24'h800008);
    end
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    if (n_vec != 33) begin
      n_fail++;
      $display("FAIL vector_count: got %0d, required 33", n_vec);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    if (n_fail != 0) begin
      $display("FAIL: %0d miscompares", n_fail);
    end else begin
      $display("PASS");
    end
    $finish;
  end

endmodule
